// File: rtl/qam_demod_rx.sv
// qam_demod_rx
//   Receive side of the 16-QAM loopback chain. Slices 3-bit signed I/Q
//   levels back to Gray-coded 2-bit symbols, re-serialises each symbol
//   MSB first (I[1], I[0], Q[1], Q[0]) and checks the resulting bit
//   stream against the degree-3 m-sequence defined by LFSR_TAPS.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   sym_valid  one-cycle strobe, Siga/Sigb carry a new symbol
//   Siga/Sigb  I/Q levels, 3-bit two's complement
//   bit_out    recovered serial bit (0 when bit_valid is low)
//   bit_valid  bit_out qualifier, high for 4 cycles per accepted symbol
//   locked     m-sequence checker is in CHECK
//   err_cnt    saturating count of mismatches seen while locked
//   overrun    sticky, a symbol arrived while the serialiser was busy
//
// Build option
//   QAM_RX_BER_EN  when defined, err_cnt counts mismatches and a
//                  WIN_LEN-bit supervision window drops lock after
//                  ERR_LIMIT mismatches. When undefined err_cnt is 0 and
//                  lock is only left through rst.
//
// Checker states
//   state    | meaning
//   ST_ACQ   | loading 3 received bits into hist, no comparison
//   ST_CHECK | locked, each received bit compared with the predicted one

module qam_demod_rx #(
  parameter logic [2:0]  LFSR_TAPS = 3'b110,
  parameter int unsigned WIN_LEN   = 32,
  parameter int unsigned ERR_LIMIT = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_valid,
  input  logic [2:0]       Siga,
  input  logic [2:0]       Sigb,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt,
  output logic             overrun
);

  if (WIN_LEN < 2 || ERR_LIMIT < 1) begin : g_bad_cfg
    $error("qam_demod_rx: WIN_LEN must be >= 2 and ERR_LIMIT >= 1");
  end

  // Decision thresholds sit halfway between nominal levels -3/-1/+1/+3;
  // the tie at 0 goes to 11 and the unused code -4 to 00.
  function automatic logic [1:0] slice(input logic [2:0] v);
    logic [1:0] g;
    case (v)
      3'b100, 3'b101, 3'b110: g = 2'b00;
      3'b111:                 g = 2'b01;
      3'b000, 3'b001:         g = 2'b11;
      default:                g = 2'b10;
    endcase
    return g;
  endfunction

  // ---------------------------------------------------------------
  // Serialiser: ser_left counts bits still to emit after the one
  // currently on bit_out, so a strobe is accepted once ser_left is 0,
  // i.e. on the cycle the last bit of the previous symbol is shown.
  // ---------------------------------------------------------------
  logic [2:0] ser_sr;
  logic [1:0] ser_left;
  logic [3:0] sym_bits;

  assign sym_bits = {slice(Siga), slice(Sigb)};

  always_ff @(posedge clk) begin
    if (rst) begin
      ser_sr    <= '0;
      ser_left  <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (ser_left != 2'd0) begin
      bit_out   <= ser_sr[2];
      ser_sr    <= {ser_sr[1:0], 1'b0};
      ser_left  <= ser_left - 2'd1;
      bit_valid <= 1'b1;
      if (sym_valid) overrun <= 1'b1;
    end else if (sym_valid) begin
      bit_out   <= sym_bits[3];
      ser_sr    <= sym_bits[2:0];
      ser_left  <= 2'd3;
      bit_valid <= 1'b1;
    end else begin
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------
  // m-sequence checker, fed from the registered serial output
  // ---------------------------------------------------------------
  typedef enum logic {ST_ACQ, ST_CHECK} state_t;

  state_t     state, state_nxt;
  logic [2:0] hist, hist_nxt;
  logic [1:0] acq_cnt, acq_cnt_nxt;

  assign locked = (state == ST_CHECK);

`ifdef QAM_RX_BER_EN
  localparam int WIN_W = $clog2(WIN_LEN);
  localparam int ERR_W = $clog2(ERR_LIMIT + 1);

  logic             exp_bit, mismatch;
  logic [CNT_W-1:0] err_cnt_nxt;
  logic [WIN_W-1:0] win_cnt, win_cnt_nxt;
  logic [ERR_W-1:0] win_err, win_err_nxt, win_err_inc;

  assign exp_bit     = ^(hist & LFSR_TAPS);
  assign mismatch    = (bit_out != exp_bit);
  assign win_err_inc = win_err + ERR_W'(mismatch);
`else
  assign err_cnt = '0;
`endif

  always_comb begin
    state_nxt   = state;
    hist_nxt    = hist;
    acq_cnt_nxt = acq_cnt;
`ifdef QAM_RX_BER_EN
    err_cnt_nxt = err_cnt;
    win_cnt_nxt = win_cnt;
    win_err_nxt = win_err;
`endif
    if (bit_valid) begin
      // The received bit always enters hist, even when it is wrong.
      hist_nxt = {hist[1:0], bit_out};
      case (state)
        ST_ACQ: begin
          if (acq_cnt == 2'd2) begin
            acq_cnt_nxt = 2'd0;
            // An all-zero history is the LFSR lock-up state; reload.
            if (hist_nxt != 3'd0) state_nxt = ST_CHECK;
          end else begin
            acq_cnt_nxt = acq_cnt + 2'd1;
          end
        end
        ST_CHECK: begin
`ifdef QAM_RX_BER_EN
          if (mismatch && (err_cnt != '1)) err_cnt_nxt = err_cnt + CNT_W'(1);
          // The limit test uses the count including this bit, so an error
          // on the last bit of a window still belongs to that window.
          if (win_err_inc >= ERR_W'(ERR_LIMIT)) begin
            state_nxt   = ST_ACQ;
            hist_nxt    = '0;
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end else if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end else begin
            win_cnt_nxt = win_cnt + WIN_W'(1);
            win_err_nxt = win_err_inc;
          end
`endif
        end
        default: state_nxt = ST_ACQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ACQ;
      hist    <= '0;
      acq_cnt <= '0;
    end else begin
      state   <= state_nxt;
      hist    <= hist_nxt;
      acq_cnt <= acq_cnt_nxt;
    end
  end

`ifdef QAM_RX_BER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
      win_cnt <= '0;
      win_err <= '0;
    end else begin
      err_cnt <= err_cnt_nxt;
      win_cnt <= win_cnt_nxt;
      win_err <= win_err_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_qam_demod_rx.sv
module tb_qam_demod_rx;

  localparam int CW    = 4;
  localparam int DEPTH = 4096;
`ifdef QAM_RX_BER_EN
  localparam bit BER = 1'b1;
`else
  localparam bit BER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, sym_valid;
  logic [2:0]    siga, sigb;
  logic          bit_out, bit_valid, locked, overrun;
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  qam_demod_rx #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .Siga(siga), .Sigb(sigb),
    .bit_out(bit_out), .bit_valid(bit_valid), .locked(locked),
    .err_cnt(err_cnt), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Per-cycle record, word layout {valid, valid&bit, locked, overrun, err_cnt}
  bit            sched_v [DEPTH];
  bit            sched_b [DEPTH];
  logic [CW+3:0] obs_w   [DEPTH];
  logic [CW+3:0] exp_w   [DEPTH];

  // Reference model state
  int busy_until;
  int m_hist, m_acq, m_err, m_win, m_werr;
  bit m_locked, m_ovr;

  int       seq_t = 0;
  bit [6:0] mpat  = 7'b0010111;   // period of taps 110 from seed 001

  function automatic bit mseq_bit(input int t);
    return mpat[6 - (t % 7)];
  endfunction

  function automatic logic [3:0] next_nib();
    logic [3:0] n;
    for (int i = 0; i < 4; i++) n[3-i] = mseq_bit(seq_t + i);
    seq_t += 4;
    return n;
  endfunction

  function automatic logic [1:0] slice_ref(input int v);
    if (v <= -2)     return 2'b00;
    else if (v == -1) return 2'b01;
    else if (v <= 1)  return 2'b11;
    else              return 2'b10;
  endfunction

  function automatic int sval(input logic [2:0] x);
    return int'($signed(x));
  endfunction

  // Any level that slices to the requested Gray pair.
  function automatic logic [2:0] level_for(input logic [1:0] g);
    int v;
    case (g)
      2'b00:   v = -2 - int'($urandom_range(0, 2));
      2'b01:   v = -1;
      2'b11:   v = int'($urandom_range(0, 1));
      default: v = 2 + int'($urandom_range(0, 1));
    endcase
    return 3'(v);
  endfunction

  task automatic m_clear();
    m_hist = 0; m_acq = 0; m_err = 0; m_win = 0; m_werr = 0;
    m_locked = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic m_bit(input bit b);
    int expb, mis;
    if (!m_locked) begin
      m_hist = ((m_hist << 1) | int'(b)) & 7;
      m_acq++;
      if (m_acq == 3) begin
        m_acq = 0;
        m_locked = (m_hist != 0);
      end
    end else begin
      expb   = ((m_hist >> 2) ^ (m_hist >> 1)) & 1;
      m_hist = ((m_hist << 1) | int'(b)) & 7;
      if (BER) begin
        mis = (int'(b) != expb) ? 1 : 0;
        if (mis == 1 && m_err < (1 << CW) - 1) m_err++;
        m_werr += mis;
        if (m_werr >= 4) begin
          m_locked = 1'b0; m_hist = 0; m_win = 0; m_werr = 0;
        end else begin
          m_win++;
          if (m_win == 32) begin m_win = 0; m_werr = 0; end
        end
      end
    end
  endtask

  // One clock cycle: record DUT and model for the current cycle, advance
  // the model, apply inputs for the next edge.
  task automatic drive(input bit r, input bit sv, input logic [2:0] a, input logic [2:0] bq);
    logic [1:0] gi, gq;
    if (cyc >= DEPTH - 8) begin
      errors++;
      $display("FAIL cycle_budget cycle %0d limit %0d", cyc, DEPTH - 8);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "cycle budget exhausted");
    end
    obs_w[cyc] = {bit_valid, bit_valid & bit_out, locked, overrun, err_cnt};
    exp_w[cyc] = {sched_v[cyc], sched_v[cyc] & sched_b[cyc], m_locked, m_ovr, CW'(m_err)};
    if (sched_v[cyc]) m_bit(sched_b[cyc]);
    if (r) begin
      for (int c = cyc + 1; c <= cyc + 4; c++) sched_v[c] = 1'b0;
      m_clear();
      busy_until = cyc + 1;
    end else if (sv) begin
      if (cyc >= busy_until) begin
        gi = slice_ref(sval(a));
        gq = slice_ref(sval(bq));
        {sched_b[cyc+1], sched_b[cyc+2], sched_b[cyc+3], sched_b[cyc+4]} = {gi, gq};
        for (int c = cyc + 1; c <= cyc + 4; c++) sched_v[c] = 1'b1;
        busy_until = cyc + 4;
      end else begin
        m_ovr = 1'b1;
      end
    end
    rst = r; sym_valid = sv; siga = a; sigb = bq;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 3'd0);
  endtask

  task automatic send_nib(input logic [3:0] nib);
    drive(1'b0, 1'b1, level_for(nib[3:2]), level_for(nib[1:0]));
    idle(3);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 3'd0, 3'd0);
    idle(1);
  endtask

  // ---------------------------------------------------------------
  task automatic test_reset();
    int c0;
    c0 = cyc;
    drive(1'b1, 1'b1, 3'b011, 3'b011);
    drive(1'b1, 1'b0, 3'd0, 3'd0);
    idle(2);
    checks++;
    if (obs_w[c0 + 2] !== '0) begin
      errors++;
      $display("FAIL reset_state got %b want %b", obs_w[c0 + 2], {(CW+4){1'b0}});
    end
    for (int c = c0; c < cyc; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        errors++;
        $display("FAIL reset_model cycle %0d got %b want %b", c, obs_w[c], exp_w[c]);
      end
    end
  endtask

  task automatic test_first_symbol();
    int s;
    logic [3:0] want;
    want = 4'b1000;
    s = cyc;
    drive(1'b0, 1'b1, 3'b011, 3'b101);
    idle(5);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_w[s+1+k][CW+3:CW+2] !== {1'b1, want[3-k]}) begin
        errors++;
        $display("FAIL first_symbol bit %0d got v/b %b want %b", k,
                 obs_w[s+1+k][CW+3:CW+2], {1'b1, want[3-k]});
      end
    end
    checks++;
    if (obs_w[s+3][CW+1] !== 1'b0 || obs_w[s+3][CW-1:0] !== '0) begin
      errors++;
      $display("FAIL first_symbol_status got locked %b err %0d want 0 0",
               obs_w[s+3][CW+1], obs_w[s+3][CW-1:0]);
    end
    for (int c = s; c < cyc; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        errors++;
        $display("FAIL first_symbol_model cycle %0d got %b want %b", c, obs_w[c], exp_w[c]);
      end
    end
  endtask

  task automatic test_slicer();
    logic [1:0] tbl [8];
    int c0, s;
    logic [1:0] got;
    tbl = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10};
    c0 = cyc;
    for (int ax = 0; ax < 2; ax++) begin
      for (int v = -4; v <= 3; v++) begin
        s = cyc;
        if (ax == 0) drive(1'b0, 1'b1, 3'(v), 3'($urandom));
        else         drive(1'b0, 1'b1, 3'($urandom), 3'(v));
        idle(3);
        drive(1'b0, 1'b0, 3'd0, 3'd0);
        got = (ax == 0) ? {obs_w[s+1][CW+2], obs_w[s+2][CW+2]}
                        : {obs_w[s+3][CW+2], obs_w[s+4][CW+2]};
        checks++;
        if (got !== tbl[v+4]) begin
          errors++;
          $display("FAIL slicer axis %0d level %0d got %b want %b", ax, v, got, tbl[v+4]);
        end
      end
    end
    for (int c = c0; c < cyc; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        errors++;
        $display("FAIL slicer_model cycle %0d got %b want %b", c, obs_w[c], exp_w[c]);
      end
    end
  endtask

  task automatic test_mseq_lock();
    int c0, s;
    c0 = cyc;
    do_reset();
    seq_t = 0;
    s = cyc;
    for (int i = 0; i < 70; i++) send_nib(next_nib());
    idle(1);
    checks++;
    if (obs_w[s+3][CW+1] !== 1'b0 || obs_w[s+4][CW+1] !== 1'b1) begin
      errors++;
      $display("FAIL lock_timing got %b%b want 01", obs_w[s+3][CW+1], obs_w[s+4][CW+1]);
    end
    checks++;
    if (obs_w[cyc-1][CW-1:0] !== '0) begin
      errors++;
      $display("FAIL clean_err_cnt got %0d want 0", obs_w[cyc-1][CW-1:0]);
    end
    for (int c = c0; c < cyc; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        errors++;
        $display("FAIL mseq_model cycle %0d got %b want %b", c, obs_w[c], exp_w[c]);
      end
    end
  endtask

  task automatic test_bit_errors();
    int c0, c1, e0, e1, delta;
    bit ok, stayed, saw_drop;
    c0 = cyc;
    e0 = int'(err_cnt);
    send_nib(next_nib() ^ 4'b0100);
    for (int i = 0; i < 3; i++) send_nib(next_nib());
    e1 = int'(err_cnt);
    delta = e1 - e0;
    stayed = 1'b1;
    for (int c = c0; c < cyc; c++) if (obs_w[c][CW+1] !== 1'b1) stayed = 1'b0;
    ok = BER ? (delta >= 1 && delta <= 3) : (delta == 0);
    checks++;
    if (!ok || !stayed) begin
      errors++;
      $display("FAIL single_flip got delta %0d stayed_locked %b want delta %s locked 1",
               delta, stayed, BER ? "1..3" : "0");
    end
    c1 = cyc;
    for (int i = 0; i < 8; i++) send_nib(next_nib() ^ ((i % 2 == 0) ? 4'b1000 : 4'b0000));
    saw_drop = 1'b0;
    for (int c = c1; c < cyc; c++) if (obs_w[c][CW+1] === 1'b0) saw_drop = 1'b1;
    checks++;
    if (saw_drop !== BER) begin
      errors++;
      $display("FAIL four_flips_drop got %b want %b", saw_drop, BER);
    end
    for (int i = 0; i < 10; i++) send_nib(next_nib());
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL relock got %b want 1", locked);
    end
    for (int c = c0; c < cyc; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        errors++;
        $display("FAIL bit_error_model cycle %0d got %b want %b", c, obs_w[c], exp_w[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0, s, nv;
    c0 = cyc;
    do_reset();
    s = cyc;
    drive(1'b0, 1'b1, 3'($urandom), 3'($urandom));
    idle(1);
    drive(1'b0, 1'b1, 3'($urandom), 3'($urandom));
    idle(7);
    nv = 0;
    for (int c = s + 1; c <= s + 8; c++) nv += int'(obs_w[c][CW+3]);
    checks++;
    if (nv != 4 || obs_w[s+3][CW] !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_drop got bits %0d ovr %b/%b want 4 1/1", nv, obs_w[s+3][CW], overrun);
    end
    do_reset();
    s = cyc;
    send_nib(4'($urandom));
    drive(1'b0, 1'b1, 3'($urandom), 3'($urandom));
    idle(6);
    nv = 0;
    for (int c = s + 1; c <= s + 8; c++) nv += int'(obs_w[c][CW+3]);
    checks++;
    if (nv != 8 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back got bits %0d ovr %b want 8 0", nv, overrun);
    end
    for (int c = c0; c < cyc; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        errors++;
        $display("FAIL overrun_model cycle %0d got %b want %b", c, obs_w[c], exp_w[c]);
      end
    end
  endtask

  task automatic test_saturation();
    int c0, want;
    c0 = cyc;
    do_reset();
    seq_t = 0;
    for (int i = 0; i < 3; i++) send_nib(next_nib());
    for (int i = 0; i < 150; i++) begin
      drive(1'b0, 1'b1, 3'($urandom), 3'($urandom));
      idle(3);
    end
    idle(2);
    want = BER ? 15 : 0;
    checks++;
    if (int'(err_cnt) != want) begin
      errors++;
      $display("FAIL err_saturation got %0d want %0d", err_cnt, want);
    end
    for (int c = c0; c < cyc; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        errors++;
        $display("FAIL saturation_model cycle %0d got %b want %b", c, obs_w[c], exp_w[c]);
      end
    end
  endtask

  task automatic test_rst_mid_symbol();
    int s, nv;
    s = cyc;
    drive(1'b0, 1'b1, 3'b011, 3'b011);
    idle(1);
    drive(1'b1, 1'b0, 3'd0, 3'd0);
    idle(5);
    checks++;
    if (obs_w[s+3] !== '0 || obs_w[s+2][CW+3] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_symbol got %b (prior valid %b) want %b (prior valid 1)",
               obs_w[s+3], obs_w[s+2][CW+3], {(CW+4){1'b0}});
    end
    nv = 0;
    for (int c = s + 3; c < cyc; c++) nv += int'(obs_w[c][CW+3]);
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL rst_abort_bits got %0d want 0", nv);
    end
    for (int c = s; c < cyc; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        errors++;
        $display("FAIL rst_mid_model cycle %0d got %b want %b", c, obs_w[c], exp_w[c]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; sym_valid = 1'b0; siga = 3'd0; sigb = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    cyc = 0;
    m_clear();
    busy_until = 0;
    test_reset();
    test_first_symbol();
    test_slicer();
    test_mseq_lock();
    test_bit_errors();
    test_back_to_back();
    test_saturation();
    test_rst_mid_symbol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
